drum_arbiter: RTL and testbench

DRUM_ARBITER -- requirements
Module: drum_arbiter

---
 rtl/drum_arbiter.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_drum_arbiter.sv | 532 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drum_arbiter.sv
// -----------------------------------------------------------------------------
// drum_arbiter
//
// Shares one DRUM approximate multiplier between two requesters. A requester
// offers a signed operand pair; the arbiter grants one requester at a time,
// latches its operands, computes the approximate product in one cycle and then
// holds the result until the owning requester accepts it.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   s0_valid/s0_ready      requester 0 operand handshake
//   s0_a, s0_b             requester 0 signed operands (N and M bits)
//   s1_valid/s1_ready      requester 1 operand handshake
//   s1_a, s1_b             requester 1 signed operands (N and M bits)
//   r0_valid/r0_ready      requester 0 result handshake
//   r0_data                requester 0 product (N+M bits, 0 when not owner)
//   r1_valid/r1_ready      requester 1 result handshake
//   r1_data                requester 1 product (N+M bits, 0 when not owner)
//   busy                   high whenever an operation is in flight
//   ops_done               wrapping count of delivered results
//
// Also contains the helper modules drum_trunc and drum that implement the
// approximate multiplier itself.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// drum_trunc
//
// Reduces an unsigned magnitude to its K most significant bits, counted from
// the leading one, and forces the lowest kept bit to 1 so the truncation error
// is centred rather than always negative. Magnitudes below 2^K pass unchanged.
//
// Ports
//   mag    unsigned magnitude
//   trunc  truncated magnitude, same scale as mag
// -----------------------------------------------------------------------------
module drum_trunc #(
  parameter int W = 8,
  parameter int K = 3
) (
  input  logic [W-1:0] mag,
  output logic [W-1:0] trunc
);

  localparam int LW = (W > 1) ? $clog2(W) : 1;

  logic [LW-1:0] lead;
  logic [LW-1:0] shift;

  // Leading-one position; the highest set bit wins because it is written last.
  always_comb begin
    lead = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) begin
        lead = LW'(i);
      end
    end
  end

  // Keep K bits starting at the leading one, set the lowest of them, and put
  // the value back at its original scale.
  always_comb begin
    shift = '0;
    trunc = mag;
    if (int'(lead) >= K) begin
      shift = lead - LW'(K - 1);
      trunc = ((mag >> shift) | W'(1)) << shift;
    end
  end

endmodule

// -----------------------------------------------------------------------------
// drum
//
// Combinational DRUM approximate signed multiplier. Signs are stripped with a
// ones-complement (bitwise invert), the magnitudes are truncated by
// drum_trunc, multiplied exactly, and the sign is re-applied by inverting the
// product again. The ones-complement handling is deliberate: it matches the
// reference DRUM behaviour bit for bit.
//
// Ports
//   a  signed operand, N bits
//   b  signed operand, M bits
//   r  approximate product, N+M bits
// -----------------------------------------------------------------------------
module drum #(
  parameter int K = 3,
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic [N-1:0]   a,
  input  logic [M-1:0]   b,
  output logic [N+M-1:0] r
);

  logic           sign;
  logic [N-1:0]   mag_a;
  logic [M-1:0]   mag_b;
  logic [N-1:0]   trunc_a;
  logic [M-1:0]   trunc_b;
  logic [N+M-1:0] prod;

  assign sign  = a[N-1] ^ b[M-1];
  assign mag_a = a[N-1] ? ~a : a;
  assign mag_b = b[M-1] ? ~b : b;

  drum_trunc #(.W(N), .K(K)) u_trunc_a (
    .mag   (mag_a),
    .trunc (trunc_a)
  );

  drum_trunc #(.W(M), .K(K)) u_trunc_b (
    .mag   (mag_b),
    .trunc (trunc_b)
  );

  // Both magnitudes have a clear top bit, so the zero-extended product fits.
  assign prod = {{M{1'b0}}, trunc_a} * {{N{1'b0}}, trunc_b};
  assign r    = sign ? ~prod : prod;

endmodule

// -----------------------------------------------------------------------------
// drum_arbiter (top)
// -----------------------------------------------------------------------------
module drum_arbiter #(
  parameter int K = 3,
  parameter int N = 8,
  parameter int M = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s0_valid,
  output logic           s0_ready,
  input  logic [N-1:0]   s0_a,
  input  logic [M-1:0]   s0_b,
  input  logic           s1_valid,
  output logic           s1_ready,
  input  logic [N-1:0]   s1_a,
  input  logic [M-1:0]   s1_b,
  output logic           r0_valid,
  input  logic           r0_ready,
  output logic [N+M-1:0] r0_data,
  output logic           r1_valid,
  input  logic           r1_ready,
  output logic [N+M-1:0] r1_data,
  output logic           busy,
  output logic [15:0]    ops_done
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    HOLD
  } state_t;

  state_t state;
  state_t next_state;

  logic           prio;
  logic           id;
  logic [N-1:0]   op_a;
  logic [M-1:0]   op_b;
  logic [N+M-1:0] res;
  logic [N+M-1:0] drum_out;

  logic grant_any;
  logic grant_id;
  logic accept;
  logic result_taken;

  // The single shared multiplier only ever sees the latched operands, so its
  // output is independent of whatever the requesters drive after the grant.
  drum #(.K(K), .N(N), .M(M)) u_drum (
    .a (op_a),
    .b (op_b),
    .r (drum_out)
  );

  // Grant selection: a lone requester always wins; a tie is broken by prio,
  // which points at the requester that was not served last.
  assign grant_any = s0_valid | s1_valid;
  assign grant_id  = (s0_valid & s1_valid) ? prio : s1_valid;

  // In IDLE the granted requester's ready is high whenever its valid is high,
  // so a grant is always a completed handshake.
  assign accept       = (state == IDLE) && grant_any;
  assign result_taken = (state == HOLD) && (id ? r1_ready : r0_ready);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: CALC always lasts one cycle, HOLD waits for the owner.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (grant_any) begin
          next_state = CALC;
        end
      end
      CALC: begin
        next_state = HOLD;
      end
      HOLD: begin
        if (result_taken) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Outputs. Ready is additionally masked by rst because the state register
  // already reads IDLE during reset and would otherwise let a grant show.
  always_comb begin
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    r0_data  = '0;
    r1_data  = '0;
    busy     = (state != IDLE);
    case (state)
      IDLE: begin
        s0_ready = grant_any && !grant_id && !rst;
        s1_ready = grant_any &&  grant_id && !rst;
      end
      HOLD: begin
        r0_valid = !id;
        r1_valid =  id;
        r0_data  = id ? '0 : res;
        r1_data  = id ? res : '0;
      end
      default: begin
      end
    endcase
  end

  // Operand and owner capture on the grant handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      id   <= 1'b0;
    end else if (accept) begin
      op_a <= grant_id ? s1_a : s0_a;
      op_b <= grant_id ? s1_b : s0_b;
      id   <= grant_id;
    end
  end

  // Result register: written only in CALC so it stays frozen through HOLD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res <= '0;
    end else if (state == CALC) begin
      res <= drum_out;
    end
  end

  // Fairness pointer and completion counter move only when a result is taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio     <= 1'b0;
      ops_done <= '0;
    end else if (result_taken) begin
      prio     <= !id;
      ops_done <= ops_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_drum_arbiter.sv
// -----------------------------------------------------------------------------
// tb_drum_arbiter
//
// Self-checking bench for drum_arbiter. Expected products come from a
// behavioural DRUM model written with integer arithmetic; grant order and the
// completion count come from a transaction-level model of the arbitration rule.
// -----------------------------------------------------------------------------
module tb_drum_arbiter;

  localparam int K = 3;
  localparam int N = 8;
  localparam int M = 8;

  logic        clk;
  logic        rst;
  logic        s0_valid;
  logic        s0_ready;
  logic [7:0]  s0_a;
  logic [7:0]  s0_b;
  logic        s1_valid;
  logic        s1_ready;
  logic [7:0]  s1_a;
  logic [7:0]  s1_b;
  logic        r0_valid;
  logic        r0_ready;
  logic [15:0] r0_data;
  logic        r1_valid;
  logic        r1_ready;
  logic [15:0] r1_data;
  logic        busy;
  logic [15:0] ops_done;

  int          errors;
  int          checks;
  bit          prio_m;
  logic [15:0] ops_m;

  drum_arbiter #(.K(K), .N(N), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .s0_valid (s0_valid),
    .s0_ready (s0_ready),
    .s0_a     (s0_a),
    .s0_b     (s0_b),
    .s1_valid (s1_valid),
    .s1_ready (s1_ready),
    .s1_a     (s1_a),
    .s1_b     (s1_b),
    .r0_valid (r0_valid),
    .r0_ready (r0_ready),
    .r0_data  (r0_data),
    .r1_valid (r1_valid),
    .r1_ready (r1_ready),
    .r1_data  (r1_data),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  // Magnitude approximation: keep K bits from the leading one, round the
  // lowest kept bit up to 1.
  function automatic int approx(input int m);
    int p;
    int t;
    int s;
    if (m < (1 << K)) return m;
    t = m;
    p = 0;
    while (t > 1) begin
      t = t / 2;
      p = p + 1;
    end
    s = p - K + 1;
    t = m / (1 << s);
    if (t % 2 == 0) t = t + 1;
    return t * (1 << s);
  endfunction

  // Signed DRUM product with ones-complement sign handling.
  function automatic logic [15:0] drum_ref(input logic [7:0] a, input logic [7:0] b);
    int ia;
    int ib;
    int ma;
    int mb;
    int p;
    bit na;
    bit nb;
    ia = int'(a);
    ib = int'(b);
    na = (ia >= 128);
    nb = (ib >= 128);
    ma = na ? 255 - ia : ia;
    mb = nb ? 255 - ib : ib;
    p  = approx(ma) * approx(mb);
    if (na != nb) p = 65535 - p;
    return 16'(p);
  endfunction

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1;
    s0_valid = 0; s1_valid = 0; r0_ready = 0; r1_ready = 0;
    s0_a = 0; s0_b = 0; s1_a = 0; s1_b = 0;
    @(posedge clk); #1;
    rst = 0;
    prio_m = 0;
    ops_m = 0;
  endtask

  // Drives one isolated operation and reports what was observed.
  task automatic drive_op(input bit who, input logic [7:0] a, input logic [7:0] b,
                          output logic rdy_seen, output logic calc_valid,
                          output logic hold_valid, output logic [15:0] hold_data,
                          output logic other_valid, output logic [15:0] other_data,
                          output logic idle_after, output logic [15:0] done_cnt);
    @(posedge clk); #1;
    r0_ready = 0; r1_ready = 0;
    if (who) begin
      s1_valid = 1; s1_a = a; s1_b = b;
    end else begin
      s0_valid = 1; s0_a = a; s0_b = b;
    end
    @(negedge clk);
    rdy_seen = who ? s1_ready : s0_ready;
    @(posedge clk); #1;
    s0_valid = 0; s1_valid = 0;
    @(negedge clk);
    calc_valid = r0_valid | r1_valid;
    @(posedge clk); #1;
    if (who) r1_ready = 1; else r0_ready = 1;
    @(negedge clk);
    hold_valid  = who ? r1_valid : r0_valid;
    hold_data   = who ? r1_data : r0_data;
    other_valid = who ? r0_valid : r1_valid;
    other_data  = who ? r0_data : r1_data;
    @(posedge clk); #1;
    r0_ready = 0; r1_ready = 0;
    @(negedge clk);
    idle_after = (busy === 1'b0) && (r0_valid === 1'b0) && (r1_valid === 1'b0);
    done_cnt   = ops_done;
  endtask

  task automatic test_reset();
    s0_valid = 1; s1_valid = 1; r0_ready = 1; r1_ready = 1;
    rst = 1;
    #1;
    checks++;
    if (s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_ready: got s0=%b s1=%b expected 0 0", s0_ready, s1_ready);
    end
    checks++;
    if (r0_valid !== 1'b0 || r1_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_rvalid: got r0=%b r1=%b expected 0 0", r0_valid, r1_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (ops_done !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_ops_done: got %h expected 0000", ops_done);
    end
    checks++;
    if (r0_data !== 16'd0 || r1_data !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h %h expected 0000 0000", r0_data, r1_data);
    end
    s0_valid = 0; s1_valid = 0; r0_ready = 0; r1_ready = 0;
    rst = 0;
    prio_m = 0;
    ops_m = 0;
  endtask

  task automatic test_directed();
    logic        rdy, cv, hv, ov, idl;
    logic [15:0] hd, od, dc;
    bit          who_l [3];
    logic [7:0]  a_l [3];
    logic [7:0]  b_l [3];
    logic [15:0] exp_l [3];
    who_l[0] = 0; a_l[0] = 8'd5;   b_l[0] = 8'd3;   exp_l[0] = 16'h000F;
    who_l[1] = 1; a_l[1] = 8'd100; b_l[1] = 8'd100; exp_l[1] = 16'h3100;
    who_l[2] = 0; a_l[2] = 8'hFB;  b_l[2] = 8'd3;   exp_l[2] = 16'hFFF3;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      drive_op(who_l[i], a_l[i], b_l[i], rdy, cv, hv, hd, ov, od, idl, dc);
      ops_m = ops_m + 16'd1;
      prio_m = !who_l[i];
      checks++;
      if (rdy !== 1'b1) begin
        errors++;
        $display("[TB] FAIL dir%0d_ready: got %b expected 1", i, rdy);
      end
      checks++;
      if (cv !== 1'b0 || hv !== 1'b1) begin
        errors++;
        $display("[TB] FAIL dir%0d_latency: got calc=%b hold=%b expected 0 1", i, cv, hv);
      end
      checks++;
      if (hd !== exp_l[i]) begin
        errors++;
        $display("[TB] FAIL dir%0d_data: got %h expected %h", i, hd, exp_l[i]);
      end
      checks++;
      if (hd !== drum_ref(a_l[i], b_l[i])) begin
        errors++;
        $display("[TB] FAIL dir%0d_model: got %h expected %h", i, hd, drum_ref(a_l[i], b_l[i]));
      end
      checks++;
      if (ov !== 1'b0 || od !== 16'd0) begin
        errors++;
        $display("[TB] FAIL dir%0d_other: got valid=%b data=%h expected 0 0000", i, ov, od);
      end
      checks++;
      if (idl !== 1'b1 || dc !== ops_m) begin
        errors++;
        $display("[TB] FAIL dir%0d_done: got idle=%b ops=%h expected 1 %h", i, idl, dc, ops_m);
      end
    end
  endtask

  task automatic test_both_valid();
    int          seq [4];
    int          ngrants;
    int          cyc;
    logic [15:0] e0;
    logic [15:0] e1;
    apply_reset();
    e0 = drum_ref(8'd7, 8'd9);
    e1 = drum_ref(8'hEC, 8'd33);
    for (int i = 0; i < 4; i++) seq[i] = 2;
    @(posedge clk); #1;
    s0_valid = 1; s0_a = 8'd7;   s0_b = 8'd9;
    s1_valid = 1; s1_a = 8'hEC;  s1_b = 8'd33;
    r0_ready = 1; r1_ready = 1;
    ngrants = 0;
    cyc = 0;
    while (ngrants < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (s0_ready === 1'b1 && s1_ready === 1'b1) begin
        errors++;
        $display("[TB] FAIL both_one_ready: got s0=1 s1=1 expected at most one");
      end
      if (s0_ready === 1'b1 || s1_ready === 1'b1) begin
        seq[ngrants] = (s1_ready === 1'b1) ? 1 : 0;
        ngrants++;
      end
      if (r0_valid === 1'b1) begin
        checks++;
        if (r0_data !== e0) begin
          errors++;
          $display("[TB] FAIL both_r0_data: got %h expected %h", r0_data, e0);
        end
      end
      if (r1_valid === 1'b1) begin
        checks++;
        if (r1_data !== e1) begin
          errors++;
          $display("[TB] FAIL both_r1_data: got %h expected %h", r1_data, e1);
        end
      end
    end
    @(posedge clk); #1;
    s0_valid = 0; s1_valid = 0;
    repeat (2) @(posedge clk);
    #1;
    r0_ready = 0; r1_ready = 0;
    checks++;
    if (ngrants != 4) begin
      errors++;
      $display("[TB] FAIL both_timeout: got %0d grants expected 4", ngrants);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seq[i] != (i % 2)) begin
        errors++;
        $display("[TB] FAIL both_order%0d: got %0d expected %0d", i, seq[i], i % 2);
      end
    end
    ops_m = ops_m + 16'd4;
    prio_m = 0;
    @(negedge clk);
    checks++;
    if (ops_done !== ops_m || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL both_done: got ops=%h busy=%b expected %h 0", ops_done, busy, ops_m);
    end
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    s1_valid = 1; s1_a = 8'd100; s1_b = 8'd100;
    r0_ready = 0; r1_ready = 0;
    @(negedge clk);
    checks++;
    if (s1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_grant: got %b expected 1", s1_ready);
    end
    @(posedge clk); #1;
    s1_valid = 0; s0_valid = 1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      s0_a = 8'($urandom); s0_b = 8'($urandom);
      s1_a = 8'($urandom); s1_b = 8'($urandom);
      s1_valid = 1'($urandom_range(0, 1));
      r0_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (r1_valid !== 1'b1 || r1_data !== 16'h3100) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got valid=%b data=%h expected 1 3100", i, r1_valid, r1_data);
      end
      checks++;
      if (s0_ready !== 1'b0 || s1_ready !== 1'b0 || r0_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_nogrant%0d: got s0=%b s1=%b r0v=%b expected 0 0 0", i, s0_ready, s1_ready, r0_valid);
      end
    end
    @(posedge clk); #1;
    r1_ready = 1; r0_ready = 0; s1_valid = 0; s0_valid = 1;
    @(negedge clk);
    checks++;
    if (r1_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_last_hold: got %b expected 1", r1_valid);
    end
    @(posedge clk); #1;
    r1_ready = 0;
    ops_m = ops_m + 16'd1;
    @(negedge clk);
    checks++;
    if (r1_valid !== 1'b0 || busy !== 1'b0 || ops_done !== ops_m) begin
      errors++;
      $display("[TB] FAIL bp_complete: got r1v=%b busy=%b ops=%h expected 0 0 %h", r1_valid, busy, ops_done, ops_m);
    end
    checks++;
    if (s0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_next_grant: got %b expected 1", s0_ready);
    end
    @(posedge clk); #1;
    s0_valid = 0; r0_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    r0_ready = 0;
    ops_m = ops_m + 16'd1;
    prio_m = 1;
    @(negedge clk);
    checks++;
    if (ops_done !== ops_m || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL bp_followup: got ops=%h busy=%b expected %h 0", ops_done, busy, ops_m);
    end
  endtask

  task automatic test_reset_in_calc();
    logic        rdy, cv, hv, ov, idl;
    logic [15:0] hd, od, dc;
    apply_reset();
    @(posedge clk); #1;
    s0_valid = 1; s0_a = 8'd9; s0_b = 8'd9; r0_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    s0_valid = 0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rc_in_calc: got busy=%b expected 1", busy);
    end
    rst = 1;
    #1;
    checks++;
    if (busy !== 1'b0 || r0_valid !== 1'b0 || ops_done !== 16'd0) begin
      errors++;
      $display("[TB] FAIL rc_immediate: got busy=%b r0v=%b ops=%h expected 0 0 0000", busy, r0_valid, ops_done);
    end
    @(posedge clk); #1;
    rst = 0;
    prio_m = 0;
    ops_m = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (r0_valid !== 1'b0 || r1_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 16'd0) begin
        errors++;
        $display("[TB] FAIL rc_quiet%0d: got r0v=%b r1v=%b busy=%b ops=%h expected 0 0 0 0000", i, r0_valid, r1_valid, busy, ops_done);
      end
    end
    r0_ready = 0;
    drive_op(0, 8'd9, 8'd9, rdy, cv, hv, hd, ov, od, idl, dc);
    ops_m = ops_m + 16'd1;
    prio_m = 1;
    checks++;
    if (rdy !== 1'b1 || hv !== 1'b1 || hd !== drum_ref(8'd9, 8'd9)) begin
      errors++;
      $display("[TB] FAIL rc_next_op: got rdy=%b valid=%b data=%h expected 1 1 %h", rdy, hv, hd, drum_ref(8'd9, 8'd9));
    end
    checks++;
    if (dc !== 16'd1 || idl !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rc_next_done: got ops=%h idle=%b expected 0001 1", dc, idl);
    end
  endtask

  task automatic test_random();
    bit          v0, v1;
    logic [7:0]  a0, b0, a1, b1;
    int          g;
    int          hold_n;
    logic [15:0] exp;
    logic        ov, xv;
    logic [15:0] od, xd;
    for (int n = 0; n < 60; n++) begin
      v0 = 1'($urandom_range(0, 1));
      v1 = 1'($urandom_range(0, 1));
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      @(posedge clk); #1;
      s0_valid = v0; s0_a = a0; s0_b = b0;
      s1_valid = v1; s1_a = a1; s1_b = b1;
      r0_ready = 0; r1_ready = 0;
      @(negedge clk);
      if (!v0 && !v1)     g = -1;
      else if (v0 && !v1) g = 0;
      else if (!v0 && v1) g = 1;
      else                g = int'(prio_m);
      checks++;
      if (s0_ready !== (g == 0) || s1_ready !== (g == 1)) begin
        errors++;
        $display("[TB] FAIL rnd%0d_grant: got s0=%b s1=%b expected grant %0d", n, s0_ready, s1_ready, g);
      end
      if (g < 0) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rnd%0d_idle: got busy=%b expected 0", n, busy);
        end
      end else begin
        exp = (g == 0) ? drum_ref(a0, b0) : drum_ref(a1, b1);
        hold_n = $urandom_range(0, 3);
        @(posedge clk); #1;
        s0_valid = 1'($urandom_range(0, 1)); s0_a = 8'($urandom); s0_b = 8'($urandom);
        s1_valid = 1'($urandom_range(0, 1)); s1_a = 8'($urandom); s1_b = 8'($urandom);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || r0_valid !== 1'b0 || r1_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
          errors++;
          $display("[TB] FAIL rnd%0d_calc: got busy=%b r0v=%b r1v=%b s0r=%b s1r=%b expected 1 0 0 0 0", n, busy, r0_valid, r1_valid, s0_ready, s1_ready);
        end
        for (int h = 0; h <= hold_n; h++) begin
          @(posedge clk); #1;
          s0_valid = 1'($urandom_range(0, 1)); s0_a = 8'($urandom); s0_b = 8'($urandom);
          s1_valid = 1'($urandom_range(0, 1)); s1_a = 8'($urandom); s1_b = 8'($urandom);
          if (g == 0) begin
            r0_ready = 0; r1_ready = 1'($urandom_range(0, 1));
          end else begin
            r1_ready = 0; r0_ready = 1'($urandom_range(0, 1));
          end
          @(negedge clk);
          ov = (g == 0) ? r0_valid : r1_valid;
          od = (g == 0) ? r0_data : r1_data;
          xv = (g == 0) ? r1_valid : r0_valid;
          xd = (g == 0) ? r1_data : r0_data;
          checks++;
          if (ov !== 1'b1 || od !== exp) begin
            errors++;
            $display("[TB] FAIL rnd%0d_hold%0d: got valid=%b data=%h expected 1 %h", n, h, ov, od, exp);
          end
          checks++;
          if (xv !== 1'b0 || xd !== 16'd0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rnd%0d_other%0d: got valid=%b data=%h s0r=%b s1r=%b expected 0 0000 0 0", n, h, xv, xd, s0_ready, s1_ready);
          end
        end
        @(posedge clk); #1;
        s0_valid = 0; s1_valid = 0;
        if (g == 0) r0_ready = 1; else r1_ready = 1;
        @(negedge clk);
        @(posedge clk); #1;
        r0_ready = 0; r1_ready = 0;
        ops_m = ops_m + 16'd1;
        prio_m = (g == 0);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || r0_valid !== 1'b0 || r1_valid !== 1'b0 || ops_done !== ops_m) begin
          errors++;
          $display("[TB] FAIL rnd%0d_done: got busy=%b r0v=%b r1v=%b ops=%h expected 0 0 0 %h", n, busy, r0_valid, r1_valid, ops_done, ops_m);
        end
      end
    end
  endtask

  // Guards against a stuck simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    clk = 0;
    rst = 1;
    errors = 0;
    checks = 0;
    prio_m = 0;
    ops_m = 0;
    s0_valid = 0; s1_valid = 0; r0_ready = 0; r1_ready = 0;
    s0_a = 0; s0_b = 0; s1_a = 0; s1_b = 0;
    $display("[TB] drum_arbiter bench starting");
    test_reset();
    test_directed();
    test_both_valid();
    test_backpressure();
    test_reset_in_calc();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
